// File: rtl/rfs_wifi_reader_pkg.sv
// rfs_wifi_reader_pkg: shared state encoding and default widths for the sample-memory stream reader
package rfs_wifi_reader_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/rfs_wifi_mem_stream_reader_if.sv
// rfs_wifi_mem_stream_reader_if: command, Avalon-MM read master and Avalon-ST source bundle
//   master: reader side (drives cmd_ready, avm_address/read/byteenable, src_*, busy, done, err)
//   slave:  environment side (drives cmd_*, abort, avm_waitrequest/readdata/readdatavalid, src_ready)
interface rfs_wifi_mem_stream_reader_if
    import rfs_wifi_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0]       cmd_len;
    logic              cmd_loop;
    logic              abort;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_sop;
    logic              src_eop;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, cmd_loop, abort,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid, src_ready,
        output cmd_ready, avm_address, avm_read, avm_byteenable,
        output src_data, src_valid, src_sop, src_eop, busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, cmd_loop, abort,
        output avm_waitrequest, avm_readdata, avm_readdatavalid, src_ready,
        input  cmd_ready, avm_address, avm_read, avm_byteenable,
        input  src_data, src_valid, src_sop, src_eop, busy, done, err
    );
endinterface

// File: rtl/rfs_wifi_stream_fifo.sv
// rfs_wifi_stream_fifo: synchronous return buffer with occupancy count, flush and same-cycle push/pop
//   push/din in, pop out via dout/empty, count = occupancy, flush clears everything (wins over push/pop)
module rfs_wifi_stream_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 34
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop && cnt_q != '0;
        do_push = push && (cnt_q != (AW+1)'(DEPTH) || do_pop);
        empty   = cnt_q == '0;
        count   = cnt_q;
        dout    = mem_q[rd_q];
    end

    always_ff @(posedge clk)
        if (do_push && !flush) mem_q[wr_q] <= din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/rfs_wifi_mem_stream_reader.sv
// rfs_wifi_mem_stream_reader: Avalon-MM burst-free read master streaming sample RAM words onto Avalon-ST
//   clk, reset (async, active-high); bus (master modport): command, avm_* read master, src_* stream, busy/done/err
//   Optional RFS_WIFI_READER_LOOP_EN: cmd_loop=1 replays the buffer until abort.
module rfs_wifi_mem_stream_reader
    import rfs_wifi_reader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_WORDS  = 35000,
    parameter int FIFO_DEPTH = 8
) (
    input logic clk,
    input logic reset,
    rfs_wifi_mem_stream_reader_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
    logic [15:0]       rem_q, rem_d, len_q, len_d, ret_q, ret_d;
    logic [CW-1:0]     out_q, out_d, fifo_cnt;
    logic [CW:0]       used;
    logic              loop_q, loop_d, stall_q, stall_d, done_q, done_d, err_q, err_d;
    logic              loop_in, range_bad, issue, push, pop, flush, empty;
    logic [DATA_W+1:0] dout;

`ifdef RFS_WIFI_READER_LOOP_EN
    assign loop_in = bus.cmd_loop;
`else
    logic unused_loop;
    assign unused_loop = bus.cmd_loop;
    assign loop_in = 1'b0;
`endif

    rfs_wifi_stream_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W + 2)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({ret_q == 16'd0, ret_q == len_q - 16'd1, bus.avm_readdata}),
        .pop   (pop),
        .flush (flush),
        .dout  (dout),
        .empty (empty),
        .count (fifo_cnt)
    );

    always_comb begin
        range_bad          = 17'(bus.cmd_addr) + 17'(bus.cmd_len) > 17'(MEM_WORDS);
        // Reads in flight plus buffered words bound the FIFO, so returns can never overflow it
        used               = (CW+1)'(out_q) + (CW+1)'(fifo_cnt);
        bus.cmd_ready      = state_q == IDLE;
        bus.busy           = state_q != IDLE;
        bus.done           = done_q;
        bus.err            = err_q;
        bus.avm_byteenable = '1;
        bus.avm_address    = addr_q;
        // In FLUSH only a request already stalled on the bus is kept up until it is taken
        bus.avm_read       = state_q == ISSUE ? rem_q != 16'd0 && used < (CW+1)'(FIFO_DEPTH)
                                              : state_q == FLUSH && stall_q;
        issue              = bus.avm_read && !bus.avm_waitrequest;
        stall_d            = bus.avm_read && bus.avm_waitrequest;
        flush              = state_q == FLUSH;
        push               = bus.avm_readdatavalid && !flush;
        bus.src_valid      = !empty && !flush;
        pop                = bus.src_valid && bus.src_ready;
        bus.src_data       = bus.src_valid ? dout[DATA_W-1:0] : '0;
        bus.src_eop        = bus.src_valid && dout[DATA_W];
        bus.src_sop        = bus.src_valid && dout[DATA_W+1];
        state_d            = state_q;
        addr_d             = addr_q;
        base_d             = base_q;
        rem_d              = rem_q;
        len_d              = len_q;
        loop_d             = loop_q;
        done_d             = 1'b0;
        err_d              = 1'b0;
        out_d              = out_q + CW'(issue) - CW'(bus.avm_readdatavalid);
        // Return-beat index within a pass tags sop/eop as words enter the buffer
        ret_d              = push ? (ret_q == len_q - 16'd1 ? 16'd0 : ret_q + 16'd1) : ret_q;
        if (issue) begin
            addr_d = loop_q && rem_q == 16'd1 ? base_q : addr_q + 1'b1;
            rem_d  = loop_q && rem_q == 16'd1 ? len_q : rem_q - 16'd1;
        end
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                addr_d  = bus.cmd_addr;
                base_d  = bus.cmd_addr;
                rem_d   = bus.cmd_len;
                len_d   = bus.cmd_len;
                ret_d   = 16'd0;
                loop_d  = loop_in;
                err_d   = range_bad;
                done_d  = !range_bad && bus.cmd_len == 16'd0;
                state_d = !range_bad && bus.cmd_len != 16'd0 ? ISSUE : IDLE;
            end
            ISSUE: state_d = bus.abort ? FLUSH : issue && rem_q == 16'd1 && !loop_q ? DRAIN : ISSUE;
            DRAIN: begin
                done_d  = !bus.abort && out_q == '0 && empty;
                state_d = bus.abort ? FLUSH : done_d ? IDLE : DRAIN;
            end
            default: begin
                done_d  = !stall_q && out_q == '0;
                state_d = done_d ? IDLE : FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            ret_q   <= '0;
            out_q   <= '0;
            loop_q  <= 1'b0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            ret_q   <= ret_d;
            out_q   <= out_d;
            loop_q  <= loop_d;
            stall_q <= stall_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule
